// File: rtl/rename_status_table_pkg.sv
// rename_status_table_pkg
//   Shared constants and types for the rename status table.
//   NREG      : architectural register count (r0 hardwired zero)
//   REG_W     : architectural register index width
//   TAG_W     : ROB tag width
//   ROB_DEPTH : ROB entry count (2**TAG_W)
//   status_entry_t : per-register {busy, tag} mapping
package rename_status_table_pkg;

    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned TAG_W     = 5;
    localparam int unsigned ROB_DEPTH = 1 << TAG_W;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic busy;
        tag_t tag;
    } status_entry_t;

    // Next ROB tag; wraps modulo ROB_DEPTH through the TAG_W-bit result.
    function automatic tag_t tag_inc(input tag_t t);
        return t + tag_t'(1);
    endfunction

endpackage

// File: rtl/rename_status_table_src_lookup.sv
// rst_src_lookup
//   Combinational lookup of one dispatch source register.
//   Ports:
//     table_q : current status table (all registers)
//     src     : source register index
//     wr_en0  : slot 0 writes a destination this cycle
//     dest0   : slot 0 destination register
//     disp_p  : ROB dispatch pointer (slot 0 tag)
//     busy    : source value pending in ROB
//     tag     : ROB tag to read or wait on (0 when not busy)
//   BYPASS enables the intra-group forward from slot 0, used by slot 1 sources.
module rst_src_lookup
    import rename_status_table_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  status_entry_t [NREG-1:0] table_q,
    input  logic [REG_W-1:0]         src,
    input  logic                     wr_en0,
    input  logic [REG_W-1:0]         dest0,
    input  logic [TAG_W-1:0]         disp_p,
    output logic                     busy,
    output logic [TAG_W-1:0]         tag
);

    always_comb begin
        busy = 1'b0;
        tag  = '0;
        if (src != '0) begin
            // Forward is unconditional on stall/one_instr; dispatch discards
            // slot 1 results in those cycles.
            if (BYPASS && wr_en0 && (dest0 != '0) && (src == dest0)) begin
                busy = 1'b1;
                tag  = disp_p;
            end else if (table_q[src].busy) begin
                busy = 1'b1;
                tag  = table_q[src].tag;
            end
        end
    end

endmodule

// File: rtl/rename_status_table.sv
// rename_status_table
//   Dual-dispatch register status table feeding the 32-entry ROB. Tracks, per
//   architectural register, whether a producer is in flight and its ROB tag.
//   Ports:
//     clk, rst                     : clock, async active-high reset
//     stall, one_instr             : dispatch blocked / only slot 0 dispatches
//     disp_p                       : ROB dispatch pointer (slot 1 uses disp_p+1)
//     wr_en0/1, dest0/1            : slot destination writes
//     src0a/0b/1a/1b               : slot source registers
//     commit, commit2, commit_p    : ROB commits at commit_p / commit_p+1
//     commit_addr, commit_addr2    : destinations of the committing entries
//     flush                        : clear all mappings
//     busy*/tag*                   : per-source pending flag and ROB tag
module rename_status_table
    import rename_status_table_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             one_instr,
    input  logic [TAG_W-1:0] disp_p,
    input  logic             wr_en0,
    input  logic             wr_en1,
    input  logic [REG_W-1:0] dest0,
    input  logic [REG_W-1:0] dest1,
    input  logic [REG_W-1:0] src0a,
    input  logic [REG_W-1:0] src0b,
    input  logic [REG_W-1:0] src1a,
    input  logic [REG_W-1:0] src1b,
    input  logic             commit,
    input  logic             commit2,
    input  logic [TAG_W-1:0] commit_p,
    input  logic [REG_W-1:0] commit_addr,
    input  logic [REG_W-1:0] commit_addr2,
    input  logic             flush,
    output logic             busy0a,
    output logic             busy0b,
    output logic             busy1a,
    output logic             busy1b,
    output logic [TAG_W-1:0] tag0a,
    output logic [TAG_W-1:0] tag0b,
    output logic [TAG_W-1:0] tag1a,
    output logic [TAG_W-1:0] tag1b
);

    status_entry_t [NREG-1:0] table_q;
    status_entry_t [NREG-1:0] table_d;

    logic       disp0_wr;
    logic       disp1_wr;
    tag_t       disp_p1;
    tag_t       commit_p1;

    assign disp0_wr  = !stall && wr_en0 && (dest0 != '0);
    assign disp1_wr  = !stall && !one_instr && wr_en1 && (dest1 != '0);
    assign disp_p1   = tag_inc(disp_p);
    assign commit_p1 = tag_inc(commit_p);

    // Later statements win: commit < slot 0 < slot 1 < flush.
    // A commit only retires a mapping whose stored tag still names it;
    // otherwise a younger producer owns the register.
    always_comb begin
        table_d = table_q;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (commit && (commit_addr == REG_W'(i)) && (table_q[i].tag == commit_p))
                table_d[i].busy = 1'b0;
            if (commit2 && (commit_addr2 == REG_W'(i)) && (table_q[i].tag == commit_p1))
                table_d[i].busy = 1'b0;
            if (disp0_wr && (dest0 == REG_W'(i)))
                table_d[i] = '{busy: 1'b1, tag: disp_p};
            if (disp1_wr && (dest1 == REG_W'(i)))
                table_d[i] = '{busy: 1'b1, tag: disp_p1};
        end
        if (flush)
            table_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            table_q <= '0;
        else
            table_q <= table_d;
    end

    rst_src_lookup #(.BYPASS(1'b0)) u_lookup_0a (
        .table_q (table_q), .src(src0a), .wr_en0(wr_en0), .dest0(dest0),
        .disp_p  (disp_p),  .busy(busy0a), .tag(tag0a)
    );

    rst_src_lookup #(.BYPASS(1'b0)) u_lookup_0b (
        .table_q (table_q), .src(src0b), .wr_en0(wr_en0), .dest0(dest0),
        .disp_p  (disp_p),  .busy(busy0b), .tag(tag0b)
    );

    rst_src_lookup #(.BYPASS(1'b1)) u_lookup_1a (
        .table_q (table_q), .src(src1a), .wr_en0(wr_en0), .dest0(dest0),
        .disp_p  (disp_p),  .busy(busy1a), .tag(tag1a)
    );

    rst_src_lookup #(.BYPASS(1'b1)) u_lookup_1b (
        .table_q (table_q), .src(src1b), .wr_en0(wr_en0), .dest0(dest0),
        .disp_p  (disp_p),  .busy(busy1b), .tag(tag1b)
    );

endmodule

// File: tb/tb_rename_status_table.sv
module tb_rename_status_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall, one_instr, flush;
    logic [4:0] disp_p;
    logic       wr_en0, wr_en1;
    logic [4:0] dest0, dest1;
    logic [4:0] src0a, src0b, src1a, src1b;
    logic       commit, commit2;
    logic [4:0] commit_p, commit_addr, commit_addr2;
    logic       busy0a, busy0b, busy1a, busy1b;
    logic [4:0] tag0a, tag0b, tag1a, tag1b;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    rename_status_table dut (
        .clk(clk), .rst(rst), .stall(stall), .one_instr(one_instr),
        .disp_p(disp_p), .wr_en0(wr_en0), .wr_en1(wr_en1),
        .dest0(dest0), .dest1(dest1),
        .src0a(src0a), .src0b(src0b), .src1a(src1a), .src1b(src1b),
        .commit(commit), .commit2(commit2), .commit_p(commit_p),
        .commit_addr(commit_addr), .commit_addr2(commit_addr2),
        .flush(flush),
        .busy0a(busy0a), .busy0b(busy0b), .busy1a(busy1a), .busy1b(busy1b),
        .tag0a(tag0a), .tag0b(tag0b), .tag1a(tag1a), .tag1b(tag1b)
    );

    task automatic idle();
        stall = 0; one_instr = 0; flush = 0; disp_p = 0;
        wr_en0 = 0; wr_en1 = 0; dest0 = 0; dest1 = 0;
        src0a = 0; src0b = 0; src1a = 0; src1b = 0;
        commit = 0; commit2 = 0; commit_p = 0; commit_addr = 0; commit_addr2 = 0;
    endtask

    // Advance past the next rising edge; inputs change 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        src0a = 5; src0b = 6; src1a = 7; src1b = 31;
        tick();
        ncmp++;
        if ({busy0a, tag0a, busy0b, tag0b, busy1a, tag1a, busy1b, tag1b} !== 24'd0) begin
            nfail++;
            $display("FAIL reset_outputs: got %b%0d %b%0d %b%0d %b%0d, expected all 0",
                     busy0a, tag0a, busy0b, tag0b, busy1a, tag1a, busy1b, tag1b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dispatch();
        idle();
        disp_p = 3; wr_en0 = 1; dest0 = 5; wr_en1 = 1; dest1 = 6;
        tick();
        idle();
        src0a = 5; src0b = 6; src1a = 7; src1b = 0;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b1, 5'd3}) begin
            nfail++; $display("FAIL disp_r5: got busy=%b tag=%0d, expected busy=1 tag=3", busy0a, tag0a);
        end
        ncmp++;
        if ({busy0b, tag0b} !== {1'b1, 5'd4}) begin
            nfail++; $display("FAIL disp_r6: got busy=%b tag=%0d, expected busy=1 tag=4", busy0b, tag0b);
        end
        ncmp++;
        if ({busy1a, tag1a} !== {1'b0, 5'd0}) begin
            nfail++; $display("FAIL disp_r7: got busy=%b tag=%0d, expected busy=0 tag=0", busy1a, tag1a);
        end
        ncmp++;
        if ({busy1b, tag1b} !== {1'b0, 5'd0}) begin
            nfail++; $display("FAIL src_r0: got busy=%b tag=%0d, expected busy=0 tag=0", busy1b, tag1b);
        end
    endtask

    task automatic test_bypass();
        idle();
        disp_p = 10; wr_en0 = 1; dest0 = 5; wr_en1 = 1; dest1 = 5;
        src1a = 5; src1b = 6; src0a = 5;
        #1;
        ncmp++;
        if ({busy1a, tag1a} !== {1'b1, 5'd10}) begin
            nfail++; $display("FAIL bypass_1a: got busy=%b tag=%0d, expected busy=1 tag=10", busy1a, tag1a);
        end
        ncmp++;
        if ({busy1b, tag1b} !== {1'b1, 5'd4}) begin
            nfail++; $display("FAIL nobypass_1b: got busy=%b tag=%0d, expected busy=1 tag=4", busy1b, tag1b);
        end
        ncmp++;
        if ({busy0a, tag0a} !== {1'b1, 5'd3}) begin
            nfail++; $display("FAIL slot0_no_bypass: got busy=%b tag=%0d, expected busy=1 tag=3", busy0a, tag0a);
        end
        tick();
        idle();
        src0a = 5;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b1, 5'd11}) begin
            nfail++; $display("FAIL slot1_wins_r5: got busy=%b tag=%0d, expected busy=1 tag=11", busy0a, tag0a);
        end
        // Bypass still reported while stalled, but the table must not change.
        idle();
        stall = 1; disp_p = 12; wr_en0 = 1; dest0 = 7; src1a = 7; src0a = 7;
        #1;
        ncmp++;
        if ({busy1a, tag1a} !== {1'b1, 5'd12}) begin
            nfail++; $display("FAIL bypass_stall: got busy=%b tag=%0d, expected busy=1 tag=12", busy1a, tag1a);
        end
        tick();
        idle();
        src0a = 7;
        dest0 = 0; wr_en0 = 1; src1a = 0;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b0, 5'd0}) begin
            nfail++; $display("FAIL stall_no_write: got busy=%b tag=%0d, expected busy=0 tag=0", busy0a, tag0a);
        end
        ncmp++;
        if ({busy1a, tag1a} !== {1'b0, 5'd0}) begin
            nfail++; $display("FAIL bypass_r0: got busy=%b tag=%0d, expected busy=0 tag=0", busy1a, tag1a);
        end
        tick();
    endtask

    task automatic test_commit();
        idle();
        disp_p = 4; wr_en0 = 1; dest0 = 8;
        tick();
        idle();
        commit = 1; commit_p = 4; commit_addr = 8; src0a = 8;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b1, 5'd4}) begin
            nfail++; $display("FAIL commit_cycle_visible: got busy=%b tag=%0d, expected busy=1 tag=4", busy0a, tag0a);
        end
        tick();
        idle();
        src0a = 8;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b0, 5'd0}) begin
            nfail++; $display("FAIL commit_clears: got busy=%b tag=%0d, expected busy=0 tag=0", busy0a, tag0a);
        end
        disp_p = 9; wr_en0 = 1; dest0 = 8;
        tick();
        idle();
        commit = 1; commit_p = 4; commit_addr = 8;
        tick();
        idle();
        src0a = 8;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b1, 5'd9}) begin
            nfail++; $display("FAIL stale_commit: got busy=%b tag=%0d, expected busy=1 tag=9", busy0a, tag0a);
        end
        commit2 = 1; commit_p = 8; commit_addr2 = 8;
        tick();
        idle();
        src0a = 8;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b0, 5'd0}) begin
            nfail++; $display("FAIL commit2_clears: got busy=%b tag=%0d, expected busy=0 tag=0", busy0a, tag0a);
        end
    endtask

    task automatic test_commit_vs_dispatch();
        idle();
        disp_p = 2; wr_en0 = 1; dest0 = 9;
        tick();
        idle();
        commit = 1; commit_p = 2; commit_addr = 9;
        disp_p = 20; wr_en0 = 1; dest0 = 9;
        tick();
        idle();
        src0b = 9;
        #1;
        ncmp++;
        if ({busy0b, tag0b} !== {1'b1, 5'd20}) begin
            nfail++; $display("FAIL dispatch_over_commit: got busy=%b tag=%0d, expected busy=1 tag=20", busy0b, tag0b);
        end
    endtask

    task automatic test_wrap_stall_one();
        idle();
        disp_p = 31; wr_en0 = 1; dest0 = 1; wr_en1 = 1; dest1 = 2;
        tick();
        idle();
        src0a = 1; src0b = 2;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b1, 5'd31}) begin
            nfail++; $display("FAIL wrap_r1: got busy=%b tag=%0d, expected busy=1 tag=31", busy0a, tag0a);
        end
        ncmp++;
        if ({busy0b, tag0b} !== {1'b1, 5'd0}) begin
            nfail++; $display("FAIL wrap_r2: got busy=%b tag=%0d, expected busy=1 tag=0", busy0b, tag0b);
        end
        // commit_p+1 wraps to 0, matching r2's tag.
        commit2 = 1; commit_p = 31; commit_addr2 = 2;
        tick();
        idle();
        src0a = 1; src0b = 2;
        #1;
        ncmp++;
        if ({busy0b, tag0b, busy0a, tag0a} !== {1'b0, 5'd0, 1'b1, 5'd31}) begin
            nfail++; $display("FAIL commit2_wrap: got r2=%b/%0d r1=%b/%0d, expected r2=0/0 r1=1/31",
                              busy0b, tag0b, busy0a, tag0a);
        end
        idle();
        stall = 1; disp_p = 5; wr_en0 = 1; dest0 = 3; wr_en1 = 1; dest1 = 4;
        tick();
        idle();
        src0a = 3; src0b = 4;
        #1;
        ncmp++;
        if ({busy0a, tag0a, busy0b, tag0b} !== 12'd0) begin
            nfail++; $display("FAIL stall_holds: got r3=%b/%0d r4=%b/%0d, expected 0/0 0/0",
                              busy0a, tag0a, busy0b, tag0b);
        end
        one_instr = 1; disp_p = 6; wr_en0 = 1; dest0 = 3; wr_en1 = 1; dest1 = 4;
        tick();
        idle();
        src0a = 3; src0b = 4;
        #1;
        ncmp++;
        if ({busy0a, tag0a, busy0b, tag0b} !== {1'b1, 5'd6, 1'b0, 5'd0}) begin
            nfail++; $display("FAIL one_instr: got r3=%b/%0d r4=%b/%0d, expected 1/6 0/0",
                              busy0a, tag0a, busy0b, tag0b);
        end
    endtask

    task automatic test_flush();
        idle();
        flush = 1; disp_p = 7; wr_en0 = 1; dest0 = 10; wr_en1 = 1; dest1 = 11;
        tick();
        idle();
        src0a = 5; src0b = 6; src1a = 10; src1b = 3;
        #1;
        ncmp++;
        if ({busy0a, tag0a, busy0b, tag0b, busy1a, tag1a, busy1b, tag1b} !== 24'd0) begin
            nfail++; $display("FAIL flush_clears: got %b%0d %b%0d %b%0d %b%0d, expected all 0",
                              busy0a, tag0a, busy0b, tag0b, busy1a, tag1a, busy1b, tag1b);
        end
    endtask

    task automatic test_async_reset();
        idle();
        disp_p = 13; wr_en0 = 1; dest0 = 12;
        tick();
        idle();
        src0a = 12;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b1, 5'd13}) begin
            nfail++; $display("FAIL pre_reset_r12: got busy=%b tag=%0d, expected busy=1 tag=13", busy0a, tag0a);
        end
        #1 rst = 1'b1;
        #1;
        ncmp++;
        if ({busy0a, tag0a} !== {1'b0, 5'd0}) begin
            nfail++; $display("FAIL async_reset: got busy=%b tag=%0d, expected busy=0 tag=0", busy0a, tag0a);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_bypass();
        test_commit();
        test_commit_vs_dispatch();
        test_wrap_stall_one();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/rename_status_table.md
Name: rename_status_table

Overview:
- Dual-dispatch register status table, directly upstream of the 32-entry reorder buffer.
- Maps each architectural register to the ROB tag of its youngest in-flight producer.
- Supplies per-source busy/tag to dispatch, which uses them to form ROB read tags.
- Retires mappings from the ROB's dual commit outputs and clears everything on branch-mispredict flush.

Parameters:
NREG, 32, number of architectural registers (register 0 is hardwired zero and never renamed)
TAG_W, 5, ROB tag width (ROB depth = 2**TAG_W)
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  dispatch blocked (ROB full or downstream stall); table takes no dispatch updates
one_instr  in  1  only slot 0 dispatches this cycle
disp_p  in  TAG_W  ROB dispatch pointer; slot 0 gets tag disp_p, slot 1 gets disp_p+1 (mod 2**TAG_W)
wr_en0, wr_en1  in  1  slot writes a destination register
dest0, dest1  in  REG_W  slot destination register
src0a, src0b, src1a, src1b  in  REG_W  slot source registers
commit, commit2  in  1  ROB commits entry at commit_p / commit_p+1
commit_p  in  TAG_W  ROB commit pointer
commit_addr, commit_addr2  in  REG_W  architectural destinations of the committing entries
flush  in  1  mispredict recovery; clear all mappings
busy0a, busy0b, busy1a, busy1b  out  1  source value pending in ROB
tag0a, tag0b, tag1a, tag1b  out  TAG_W  ROB tag to read or wait on (0 when not busy)

Behaviour:
- State: per register, busy bit and TAG_W tag. Reset (async, rst=1): all busy=0, tags=0; all outputs therefore 0.
- Lookup is combinational from current state (zero latency).
- Source register 0 always reports busy=0, tag=0.
- Intra-group bypass, slot 1 sources only: if wr_en0 and dest0!=0 and the source equals dest0, report busy=1, tag=disp_p. This overrides table contents, including when one_instr or stall is asserted; dispatch ignores slot 1 in those cases.
- A mapping whose producer commits this cycle still reports busy=1 and its tag. The ROB entry data remains readable that cycle.
- Update priority per register, applied at the clock edge, lowest to highest:
  (1) commit: for commit, clear busy only if the stored tag equals commit_p; for commit2, clear busy only if the stored tag equals commit_p+1. A mismatch means a younger producer already remapped the register; leave it.
  (2) dispatch slot 0: if !stall and wr_en0 and dest0!=0, set busy=1, tag=disp_p.
  (3) dispatch slot 1: if !stall and !one_instr and wr_en1 and dest1!=0, set busy=1, tag=disp_p+1.
  (4) flush: all busy=0, tags=0, overriding (1)-(3).
- Slot 1 overrides slot 0 when both slots write the same destination.
- Dispatch overrides a same-cycle commit to the same register.
- Tag arithmetic wraps modulo 2**TAG_W (31+1=0).
- commit and commit2 may both target the same register with different tags; each compare is independent.
- Reset asserted mid-operation clears state immediately, independent of clk.

Decomposition:
- Shared package holds: NREG, REG_W, TAG_W, ROB_DEPTH, and a status-entry typedef {busy, tag}.
- Natural sub-module: rst_src_lookup, a combinational per-source lookup with the zero-register rule and the slot-0 bypass. It is instantiated 4 times (bypass enabled only for slot 1 instances).

Test Plan:
- Reset, then dispatch two writes with disp_p=3 (dest0=5, dest1=6) -> next cycle src=5 gives busy=1, tag=3; src=6 gives busy=1, tag=4; src=7 gives busy=0, tag=0.
- Same cycle: slot 0 writes r5, slot 1 reads r5, disp_p=10 -> busy1a=1, tag1a=10 combinationally. Slot 1 also writes r5 -> next cycle r5 maps to tag=11.
- r8 mapped to tag 4; commit with commit_p=4, commit_addr=8 -> r8 busy=0. Repeat with r8 remapped to tag 9, then commit tag 4 -> r8 stays busy, tag=9.
- Same edge: commit clears r9 (tag 2) and slot 0 dispatches r9 with disp_p=20 -> r9 busy=1, tag=20.
- disp_p=31 with two writes (r1, r2) -> r1 tag=31, r2 tag=0. stall=1 with writes -> no change. one_instr=1 -> only slot 0 updates.
- Several mappings busy, flush=1 coincident with a dispatch -> all busy=0 next cycle. Async rst pulse between clock edges -> all outputs 0 immediately.
